digit_scan_ctrl: RTL and testbench
==================================

# digit_scan_ctrl

Upstream scan sequencer for the 4-digit display path. Holds four 4-bit digit values in a small register file. Cycles a 2-bit select index `w` at a prescaled rate. `w` drives the 2-to-4 active-low digit-select decoder directly. Presents the selected digit's value on `digit`, inserts an optional blanking gap between digits to suppress ghosting, and flags each completed frame.

## Interface
- `DIV`, default 4: SHOW dwell per digit in clock cycles; legal range 1..65535.
- `BLANK_CYC`, default 2: blanking gap per digit in clock cycles; legal range 1..255; ignored when blanking is compiled out.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: scan enable, level-sensitive.
- `wr_en` in 1: digit register write strobe.
- `wr_addr` in 2: digit register index.
- `wr_data` in 4: digit value.
- `w` out 2: digit select index, registered; feeds the decoder.
- `digit` out 4: value of digit register `w`, combinational read.
- `blank` out 1: registered; 1 means the display must be dark.
- `frame_done` out 1: registered one-cycle pulse at frame wrap.

## Operation
- FSM states:
  - IDLE: `blank`=1.
  - SHOW: `blank`=0.
  - BLANK: `blank`=1; only exists with `DIGIT_SCAN_BLANKING_EN`.
- Reset (`rst_n`=0 at an edge), regardless of `en`:
  - state=IDLE, `w`=0, prescaler=0, blank counter=0.
  - all four digit registers=0.
  - outputs: `blank`=1, `frame_done`=0, `digit`=0.
- IDLE -> SHOW: on the edge where `en`=1. `w` stays 0 and the prescaler clears.
- SHOW:
  - The prescaler counts 0..DIV-1.
  - At count DIV-1 it goes to BLANK, or with blanking compiled out it advances `w` and stays in SHOW.
- BLANK:
  - `w` is held.
  - Counts BLANK_CYC cycles, then advances `w` and returns to SHOW.
- Advance rules:
  - `w` <= `w`+1, modulo 4 (3 -> 0).
  - `frame_done`=1 for exactly the one cycle in which `w` becomes 0 by wrap. It never asserts on entry from IDLE.
- `en`=0 sampled in SHOW or BLANK:
  - Next state IDLE; `w`=0, prescaler=0, `blank`=1.
  - No `frame_done`.
  - A partial frame is discarded.
- Register file:
  - A write on an edge with `wr_en`=1 stores `wr_data` at `wr_addr`.
  - Writes are accepted in every state, including IDLE.
  - `digit` shows the new value from the cycle after the write edge, also when `wr_addr`==`w`.
- Simultaneous write and `w` advance: the write lands and `digit` reads the new `w`'s register. No ordering hazard.
- Reset mid-scan takes priority over `en`, write and advance.

## Timing
- Latencies:
  - `en` rise to `blank` fall: 1 cycle.
  - `en` fall to `blank`=1 and `w`=0: 1 cycle.
- Per-digit period: DIV+BLANK_CYC cycles with blanking, DIV cycles without.
- Frame period: 4x the per-digit period. `frame_done` period equals the frame period under continuous `en`.
- `w` changes only on cycles where `blank`=1 was already asserted for at least one cycle (blanking build). `blank` is never 0 during a `w` transition edge.
- `digit` is combinational from `w` and the registers, so `digit` is stable whenever `w` is stable.

## Configuration
- `DIGIT_SCAN_BLANKING_EN` defined:
  - BLANK state present; `blank`=1 for BLANK_CYC cycles before every `w` advance.
- `DIGIT_SCAN_BLANKING_EN` undefined:
  - BLANK state and its counter are removed; `BLANK_CYC` is unused.
  - `w` advances directly from SHOW.
  - `blank`=0 throughout SHOW; `blank` is 1 only in IDLE.

## Test plan
All scenarios use DIV=4 and BLANK_CYC=2.
1. Reset: `rst_n`=0 for 3 edges with `en`=1 and `wr_en`=1 -> `w`=0, `blank`=1, `frame_done`=0, `digit`=0; registers read back 0.
2. Scan with blanking:
   - Stimulus: write regs 0..3 = 0xA, 0xB, 0xC, 0xD, then raise `en`.
   - Response: `blank` falls 1 cycle later, then 4 cycles SHOW / 2 cycles `blank`=1 per digit.
   - `w` sequence is 0, 1, 2, 3, 0 and `digit` tracks A, B, C, D, A.
3. Frame pulse: `en` held for 3 frames -> `frame_done` pulses once per 24 cycles, 3 pulses total, each coinciding with `w` 3 -> 0.
4. Abort and restart:
   - Drop `en` during BLANK after `w`=2 -> next cycle `w`=0, `blank`=1, no `frame_done`.
   - Re-raise `en` -> `blank`=0 one cycle later with `w`=0.
5. Live write: while `w`=2 in SHOW, write addr 2 = 0x5 -> `digit`=0x5 from the next cycle; `w` timing is unaffected.
6. Build without `DIGIT_SCAN_BLANKING_EN`: `en`=1 -> `w` advances every 4 cycles, `blank` stays 0 while enabled, `frame_done` every 16 cycles.

Source files
------------

// File: rtl/digit_scan_ctrl.sv
// Four-digit scan sequencer: digit register file, prescaled select index and blanking gaps.
// Optional blanking gap between digits is compiled in with DIGIT_SCAN_BLANKING_EN.
module digit_scan_ctrl #(
  parameter int DIV       = 4,
  parameter int BLANK_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic [1:0] w,
  output logic [3:0] digit,
  output logic       blank,
  output logic       frame_done
);

  if (DIV < 1 || DIV > 65535) begin : g_div_chk
    $error("DIV out of range 1..65535");
  end
  if (BLANK_CYC < 1 || BLANK_CYC > 255) begin : g_blank_chk
    $error("BLANK_CYC out of range 1..255");
  end

`ifdef DIGIT_SCAN_BLANKING_EN
  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHOW} state_t;
`endif

  state_t      state_q, state_d;
  logic [1:0]  w_q, w_d;
  logic [15:0] presc_q, presc_d;
  logic        blank_q, blank_d;
  logic        fd_q, fd_d;
  logic [3:0]  regs_q [4];
`ifdef DIGIT_SCAN_BLANKING_EN
  logic [7:0]  bcnt_q, bcnt_d;
`endif

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    presc_d = presc_q;
    blank_d = 1'b1;
    fd_d    = 1'b0;
`ifdef DIGIT_SCAN_BLANKING_EN
    bcnt_d  = bcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SHOW;
          w_d     = 2'd0;
          presc_d = 16'd0;
          blank_d = 1'b0;
        end
      end
      SHOW: begin
        if (!en) begin
          state_d = IDLE;
          w_d     = 2'd0;
          presc_d = 16'd0;
        end else if (presc_q == 16'(DIV - 1)) begin
          presc_d = 16'd0;
`ifdef DIGIT_SCAN_BLANKING_EN
          state_d = BLANK;
          bcnt_d  = 8'd0;
`else
          w_d     = w_q + 2'd1;
          fd_d    = (w_q == 2'd3);
          blank_d = 1'b0;
`endif
        end else begin
          presc_d = presc_q + 16'd1;
          blank_d = 1'b0;
        end
      end
`ifdef DIGIT_SCAN_BLANKING_EN
      // w is frozen while dark; it only moves on the edge that leaves BLANK
      BLANK: begin
        if (!en) begin
          state_d = IDLE;
          w_d     = 2'd0;
          presc_d = 16'd0;
          bcnt_d  = 8'd0;
        end else if (bcnt_q == 8'(BLANK_CYC - 1)) begin
          state_d = SHOW;
          bcnt_d  = 8'd0;
          w_d     = w_q + 2'd1;
          fd_d    = (w_q == 2'd3);
          blank_d = 1'b0;
        end else begin
          bcnt_d  = bcnt_q + 8'd1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        w_d     = 2'd0;
        presc_d = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= 2'd0;
      presc_q <= 16'd0;
      blank_q <= 1'b1;
      fd_q    <= 1'b0;
`ifdef DIGIT_SCAN_BLANKING_EN
      bcnt_q  <= 8'd0;
`endif
      for (int i = 0; i < 4; i++) regs_q[i] <= 4'd0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      presc_q <= presc_d;
      blank_q <= blank_d;
      fd_q    <= fd_d;
`ifdef DIGIT_SCAN_BLANKING_EN
      bcnt_q  <= bcnt_d;
`endif
      if (wr_en) regs_q[wr_addr] <= wr_data;
    end
  end

  assign w          = w_q;
  assign digit      = regs_q[w_q];
  assign blank      = blank_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: time-since-enable reference model checked every cycle,
// directed scenarios with literal expectations, then randomized enable/write/reset traffic.
module tb_digit_scan_ctrl;
  localparam int DIV       = 4;
  localparam int BLANK_CYC = 2;
`ifdef DIGIT_SCAN_BLANKING_EN
  localparam int P = DIV + BLANK_CYC;
`else
  localparam int P = DIV;
`endif

  logic       clk = 1'b0;
  logic       rst_n, en, wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [1:0] w;
  logic [3:0] digit;
  logic       blank, frame_done;

  digit_scan_ctrl #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .w(w), .digit(digit), .blank(blank), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int fd_cnt = 0;
  bit chk_on = 1'b0;

  // Model: a scan is just a count of cycles since the enabling edge.
  bit         m_act = 1'b0;
  int         m_t = 0;
  logic [3:0] m_regs [4] = '{4'd0, 4'd0, 4'd0, 4'd0};

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act = 1'b0;
      m_t   = 0;
      for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
    end else begin
      if (wr_en) m_regs[wr_addr] = wr_data;
      if (!en) begin
        m_act = 1'b0;
        m_t   = 0;
      end else if (!m_act) begin
        m_act = 1'b1;
        m_t   = 0;
      end else begin
        m_t++;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      int ew, eb, ef, ed;
      ew = m_act ? (m_t / P) % 4 : 0;
      eb = (!m_act || (m_t % P) >= DIV) ? 1 : 0;
      ef = (m_act && m_t > 0 && (m_t % (4 * P)) == 0) ? 1 : 0;
      ed = int'(m_regs[ew]);
      check("model_w", int'(w), ew);
      check("model_blank", int'(blank), eb);
      check("model_frame_done", int'(frame_done), ef);
      check("model_digit", int'(digit), ed);
      if (frame_done) fd_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; wr_en = 1'b1; wr_addr = 2'd3; wr_data = 4'hF;
    tick(1);
    chk_on = 1'b1;
    tick(2);
    check("reset_w", int'(w), 0);
    check("reset_blank", int'(blank), 1);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_digit", int'(digit), 0);

    // Load A..D while idle
    rst_n = 1'b1; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = 4'(10 + i);
      tick(1);
    end
    wr_en = 1'b0;
    check("idle_blank", int'(blank), 1);
    check("idle_digit", int'(digit), 4'hA);

    en = 1'b1;
    tick(1);
    check("en_blank_fall", int'(blank), 0);
    check("en_w0", int'(w), 0);
    check("en_digit_A", int'(digit), 4'hA);
    tick(P);
    check("scan_w1", int'(w), 1);
    check("scan_digit_B", int'(digit), 4'hB);

    // Three full frames: one pulse per frame
    fd_cnt = 0;
    tick(3 * 4 * P);
    check("frame_pulses", fd_cnt, 3);
    check("frames_w", int'(w), 1);
    tick(P);
    check("live_pre_w", int'(w), 2);

    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'h5;
    tick(1);
    wr_en = 1'b0;
    check("live_digit", int'(digit), 4'h5);
    check("live_w", int'(w), 2);

    tick(P - 2);
    check("abort_pre_w", int'(w), 2);
`ifdef DIGIT_SCAN_BLANKING_EN
    check("abort_pre_blank", int'(blank), 1);
`else
    check("abort_pre_blank", int'(blank), 0);
`endif
    en = 1'b0;
    tick(1);
    check("abort_w", int'(w), 0);
    check("abort_blank", int'(blank), 1);
    check("abort_frame_done", int'(frame_done), 0);
    en = 1'b1;
    tick(1);
    check("restart_blank", int'(blank), 0);
    check("restart_w", int'(w), 0);

    // Random traffic with occasional enable drops and resets
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 399) != 0);
      en      = ($urandom_range(0, 99) < 96);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 4'($urandom_range(0, 15));
      tick(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
